// File: rtl/id_issue_pkg.sv
// Shared decode constants for the ID/issue stage: MIPS opcode/funct fields,
// ALU operation and result-class codes, and the decoder's internal instruction classes.
package id_issue_pkg;

  localparam logic RST_ENABLE = 1'b1;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_PREF    = 6'h33;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_SYNC = 6'h0F;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam logic [7:0] ALU_NOP  = 8'h00;
  localparam logic [7:0] ALU_SRL  = 8'h02;
  localparam logic [7:0] ALU_SRA  = 8'h03;
  localparam logic [7:0] ALU_ADD  = 8'h21;
  localparam logic [7:0] ALU_SUB  = 8'h23;
  localparam logic [7:0] ALU_AND  = 8'h24;
  localparam logic [7:0] ALU_OR   = 8'h25;
  localparam logic [7:0] ALU_XOR  = 8'h26;
  localparam logic [7:0] ALU_NOR  = 8'h27;
  localparam logic [7:0] ALU_SLT  = 8'h2A;
  localparam logic [7:0] ALU_SLTU = 8'h2B;
  localparam logic [7:0] ALU_SLL  = 8'h7C;

  typedef enum logic [2:0] {
    ALU_RES_NOP   = 3'b000,
    ALU_RES_LOGIC = 3'b001,
    ALU_RES_SHIFT = 3'b010,
    ALU_RES_ARITH = 3'b100
  } alu_res_e;

  // Operand/destination layout classes the decoder maps each encoding onto.
  typedef enum logic [2:0] {
    K_RSVD, K_NOP, K_R3, K_SHV, K_SHI, K_IMM, K_LUI
  } dec_kind_e;

  function automatic logic [31:0] ext_imm16(input logic [15:0] imm, input logic sext);
    return sext ? {{16{imm[15]}}, imm} : {16'b0, imm};
  endfunction

endpackage

// File: rtl/id_issue_fwd_sel.sv
// Priority forwarding mux for one register-read port: the lowest-index
// (youngest) matching source wins; $0 and disabled reads always give zero.
module id_issue_fwd_sel #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int FWD_N  = 2
) (
  input  logic                     re_i,
  input  logic [REG_AW-1:0]        raddr_i,
  input  logic [DATA_W-1:0]        rf_data_i,
  input  logic [FWD_N-1:0]         fwd_we_i,
  input  logic [FWD_N*REG_AW-1:0]  fwd_waddr_i,
  input  logic [FWD_N*DATA_W-1:0]  fwd_wdata_i,
  input  logic [FWD_N-1:0]         fwd_pending_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     pend_o
);

  always_comb begin
    data_o = rf_data_i;
    pend_o = 1'b0;
    if (!re_i || raddr_i == '0) begin
      data_o = '0;
    end else begin
      // Walk oldest to youngest so the youngest match overwrites.
      for (int i = FWD_N - 1; i >= 0; i--) begin
        if (fwd_we_i[i] && fwd_waddr_i[i*REG_AW +: REG_AW] == raddr_i) begin
          data_o = fwd_wdata_i[i*DATA_W +: DATA_W];
          pend_o = fwd_pending_i[i];
        end
      end
    end
  end

endmodule

// File: rtl/id_issue.sv
// Decode/issue stage: decodes one instruction, resolves operands through the
// forwarding network, raises load-use stalls and registers the ID/EX boundary.
module id_issue
  import id_issue_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int FWD_N    = 2,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              pc_i,
  input  logic [31:0]              inst_i,
  input  logic                     inst_valid_i,
  output logic                     reg1_read_o,
  output logic                     reg2_read_o,
  output logic [REG_AW-1:0]        reg1_addr_o,
  output logic [REG_AW-1:0]        reg2_addr_o,
  input  logic [DATA_W-1:0]        reg1_data_i,
  input  logic [DATA_W-1:0]        reg2_data_i,
  input  logic [FWD_N-1:0]         fwd_we_i,
  input  logic [FWD_N*REG_AW-1:0]  fwd_waddr_i,
  input  logic [FWD_N*DATA_W-1:0]  fwd_wdata_i,
  input  logic [FWD_N-1:0]         fwd_pending_i,
  input  logic                     stall_i,
  input  logic                     flush_i,
  output logic                     stallreq_o,
  output logic                     ex_valid_o,
  output logic                     ex_wreg_o,
  output logic [REG_AW-1:0]        ex_waddr_o,
  output logic [ALUOP_W-1:0]       ex_aluop_o,
  output logic [ALUSEL_W-1:0]      ex_alusel_o,
  output logic [DATA_W-1:0]        ex_reg1_o,
  output logic [DATA_W-1:0]        ex_reg2_o,
  output logic [31:0]              ex_pc_o,
  output logic                     ex_rsvd_o
);

  typedef struct packed {
    logic                valid;
    logic                wreg;
    logic [REG_AW-1:0]   waddr;
    logic [ALUOP_W-1:0]  aluop;
    logic [ALUSEL_W-1:0] alusel;
    logic [DATA_W-1:0]   reg1;
    logic [DATA_W-1:0]   reg2;
    logic [31:0]         pc;
    logic                rsvd;
  } idex_t;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  dec_kind_e   kind;
  alu_res_e    sel;
  logic [7:0]  aluop;
  logic [31:0] imm32;
  logic        wreg;
  logic [4:0]  waddr;
  logic        r1_re, r2_re;
  logic [4:0]  r1_addr, r2_addr;

  assign opcode = inst_i[31:26];
  assign rs     = inst_i[25:21];
  assign rt     = inst_i[20:16];
  assign rd     = inst_i[15:11];
  assign shamt  = inst_i[10:6];
  assign funct  = inst_i[5:0];

  always_comb begin
    kind  = K_RSVD;
    sel   = ALU_RES_NOP;
    aluop = ALU_NOP;
    imm32 = '0;
    if (inst_i == '0) begin
      kind = K_NOP;
    end else begin
      case (opcode)
        OP_SPECIAL: begin
          case (funct)
            F_AND:  begin kind = K_R3;  aluop = ALU_AND;  sel = ALU_RES_LOGIC; end
            F_OR:   begin kind = K_R3;  aluop = ALU_OR;   sel = ALU_RES_LOGIC; end
            F_XOR:  begin kind = K_R3;  aluop = ALU_XOR;  sel = ALU_RES_LOGIC; end
            F_NOR:  begin kind = K_R3;  aluop = ALU_NOR;  sel = ALU_RES_LOGIC; end
            F_ADDU: begin kind = K_R3;  aluop = ALU_ADD;  sel = ALU_RES_ARITH; end
            F_SUBU: begin kind = K_R3;  aluop = ALU_SUB;  sel = ALU_RES_ARITH; end
            F_SLT:  begin kind = K_R3;  aluop = ALU_SLT;  sel = ALU_RES_ARITH; end
            F_SLTU: begin kind = K_R3;  aluop = ALU_SLTU; sel = ALU_RES_ARITH; end
            F_SLLV: begin kind = K_SHV; aluop = ALU_SLL;  sel = ALU_RES_SHIFT; end
            F_SRLV: begin kind = K_SHV; aluop = ALU_SRL;  sel = ALU_RES_SHIFT; end
            F_SRAV: begin kind = K_SHV; aluop = ALU_SRA;  sel = ALU_RES_SHIFT; end
            F_SLL:  begin kind = K_SHI; aluop = ALU_SLL;  sel = ALU_RES_SHIFT; end
            F_SRL:  begin kind = K_SHI; aluop = ALU_SRL;  sel = ALU_RES_SHIFT; end
            F_SRA:  begin kind = K_SHI; aluop = ALU_SRA;  sel = ALU_RES_SHIFT; end
            F_SYNC: kind = K_NOP;
            default: kind = K_RSVD;
          endcase
        end
        OP_ANDI:  begin kind = K_IMM; aluop = ALU_AND;  sel = ALU_RES_LOGIC; imm32 = ext_imm16(inst_i[15:0], 1'b0); end
        OP_ORI:   begin kind = K_IMM; aluop = ALU_OR;   sel = ALU_RES_LOGIC; imm32 = ext_imm16(inst_i[15:0], 1'b0); end
        OP_XORI:  begin kind = K_IMM; aluop = ALU_XOR;  sel = ALU_RES_LOGIC; imm32 = ext_imm16(inst_i[15:0], 1'b0); end
        OP_ADDIU: begin kind = K_IMM; aluop = ALU_ADD;  sel = ALU_RES_ARITH; imm32 = ext_imm16(inst_i[15:0], 1'b1); end
        OP_SLTI:  begin kind = K_IMM; aluop = ALU_SLT;  sel = ALU_RES_ARITH; imm32 = ext_imm16(inst_i[15:0], 1'b1); end
        OP_SLTIU: begin kind = K_IMM; aluop = ALU_SLTU; sel = ALU_RES_ARITH; imm32 = ext_imm16(inst_i[15:0], 1'b1); end
        OP_LUI:   begin kind = K_LUI; aluop = ALU_OR;   sel = ALU_RES_LOGIC; imm32 = {inst_i[15:0], 16'b0}; end
        OP_PREF:  kind = K_NOP;
        default:  kind = K_RSVD;
      endcase
    end

    // Unused fields must be zero; a nonzero shamt/rs makes the word reserved.
    if ((kind == K_R3 || kind == K_SHV) && shamt != 5'd0) kind = K_RSVD;
    if (kind == K_SHI && rs != 5'd0) kind = K_RSVD;
    if (kind == K_RSVD || kind == K_NOP) begin
      aluop = ALU_NOP;
      sel   = ALU_RES_NOP;
    end

    r1_re = 1'b0; r1_addr = '0;
    r2_re = 1'b0; r2_addr = '0;
    wreg  = 1'b0; waddr   = '0;
    case (kind)
      K_R3:  begin r1_re = 1'b1; r1_addr = rs; r2_re = 1'b1; r2_addr = rt; wreg = 1'b1; waddr = rd; end
      K_SHV: begin r1_re = 1'b1; r1_addr = rt; r2_re = 1'b1; r2_addr = rs; wreg = 1'b1; waddr = rd; end
      K_SHI: begin r1_re = 1'b1; r1_addr = rt; imm32 = {27'b0, shamt}; wreg = 1'b1; waddr = rd; end
      K_IMM: begin r1_re = 1'b1; r1_addr = rs; wreg = 1'b1; waddr = rt; end
      K_LUI: begin wreg = 1'b1; waddr = rt; end
      default: ;
    endcase
  end

  assign reg1_read_o = r1_re;
  assign reg2_read_o = r2_re;
  assign reg1_addr_o = REG_AW'(r1_addr);
  assign reg2_addr_o = REG_AW'(r2_addr);

  logic [DATA_W-1:0] fwd1_data, fwd2_data;
  logic              pend1, pend2;

  id_issue_fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_N(FWD_N)) u_fwd_sel1 (
    .re_i(r1_re), .raddr_i(reg1_addr_o), .rf_data_i(reg1_data_i),
    .fwd_we_i(fwd_we_i), .fwd_waddr_i(fwd_waddr_i), .fwd_wdata_i(fwd_wdata_i),
    .fwd_pending_i(fwd_pending_i), .data_o(fwd1_data), .pend_o(pend1)
  );

  id_issue_fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_N(FWD_N)) u_fwd_sel2 (
    .re_i(r2_re), .raddr_i(reg2_addr_o), .rf_data_i(reg2_data_i),
    .fwd_we_i(fwd_we_i), .fwd_waddr_i(fwd_waddr_i), .fwd_wdata_i(fwd_wdata_i),
    .fwd_pending_i(fwd_pending_i), .data_o(fwd2_data), .pend_o(pend2)
  );

  assign stallreq_o = inst_valid_i & (pend1 | pend2);

  // ID/EX boundary
  idex_t idex_d, idex_q;

  always_comb begin
    idex_d = idex_q;
    if (flush_i) begin
      idex_d = '0;
    end else if (!stall_i) begin
      if (stallreq_o) begin
        idex_d = '0;
      end else begin
        idex_d.valid  = inst_valid_i;
        idex_d.wreg   = wreg & inst_valid_i;
        idex_d.waddr  = REG_AW'(waddr);
        idex_d.aluop  = ALUOP_W'(aluop);
        idex_d.alusel = ALUSEL_W'(sel);
        idex_d.reg1   = fwd1_data;
        idex_d.reg2   = r2_re ? fwd2_data : DATA_W'(imm32);
        idex_d.pc     = pc_i;
        idex_d.rsvd   = (kind == K_RSVD) & inst_valid_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) idex_q <= '0;
    else                   idex_q <= idex_d;
  end

  assign ex_valid_o  = idex_q.valid;
  assign ex_wreg_o   = idex_q.wreg;
  assign ex_waddr_o  = idex_q.waddr;
  assign ex_aluop_o  = idex_q.aluop;
  assign ex_alusel_o = idex_q.alusel;
  assign ex_reg1_o   = idex_q.reg1;
  assign ex_reg2_o   = idex_q.reg2;
  assign ex_pc_o     = idex_q.pc;
  assign ex_rsvd_o   = idex_q.rsvd;

endmodule

// File: tb/tb_id_issue.sv
// Directed bench for id_issue: decode, forwarding priority, load-use stall and
// ID/EX stall/flush/reset control, checked with immediate assertions.
module tb_id_issue;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i, inst_i;
  logic        inst_valid_i;
  logic        reg1_read_o, reg2_read_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic [1:0]  fwd_we_i;
  logic [9:0]  fwd_waddr_i;
  logic [63:0] fwd_wdata_i;
  logic [1:0]  fwd_pending_i;
  logic        stall_i, flush_i, stallreq_o;
  logic        ex_valid_o, ex_wreg_o;
  logic [4:0]  ex_waddr_o;
  logic [7:0]  ex_aluop_o;
  logic [2:0]  ex_alusel_o;
  logic [31:0] ex_reg1_o, ex_reg2_o, ex_pc_o;
  logic        ex_rsvd_o;

  int n_assert = 0;
  int n_fail   = 0;

  id_issue dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .fwd_we_i(fwd_we_i), .fwd_waddr_i(fwd_waddr_i), .fwd_wdata_i(fwd_wdata_i),
    .fwd_pending_i(fwd_pending_i), .stall_i(stall_i), .flush_i(flush_i),
    .stallreq_o(stallreq_o), .ex_valid_o(ex_valid_o), .ex_wreg_o(ex_wreg_o),
    .ex_waddr_o(ex_waddr_o), .ex_aluop_o(ex_aluop_o), .ex_alusel_o(ex_alusel_o),
    .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o), .ex_pc_o(ex_pc_o), .ex_rsvd_o(ex_rsvd_o)
  );

  // Register file model: $n holds 0x100 + n.
  assign reg1_data_i = 32'h100 + {27'b0, reg1_addr_o};
  assign reg2_data_i = 32'h100 + {27'b0, reg2_addr_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fwd_clear();
    fwd_we_i = '0; fwd_waddr_i = '0; fwd_wdata_i = '0; fwd_pending_i = '0;
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    pc_i = 32'h0000_0100; inst_valid_i = 1'b1;
    inst_i = i_type(6'h0D, 5'd0, 5'd1, 16'h1234);
    fwd_clear();

    tick(); tick();
    check("rst_valid", 32'(ex_valid_o), 32'd0);
    check("rst_wreg",  32'(ex_wreg_o),  32'd0);
    check("rst_waddr", 32'(ex_waddr_o), 32'd0);
    check("rst_aluop", 32'(ex_aluop_o), 32'd0);
    check("rst_reg2",  ex_reg2_o,       32'd0);
    check("rst_pc",    ex_pc_o,         32'd0);

    rst = 1'b0;
    tick();
    check("ori_waddr",  32'(ex_waddr_o),  32'd1);
    check("ori_reg2",   ex_reg2_o,        32'h0000_1234);
    check("ori_reg1",   ex_reg1_o,        32'd0);
    check("ori_aluop",  32'(ex_aluop_o),  32'h25);
    check("ori_alusel", 32'(ex_alusel_o), 32'd1);
    check("ori_wreg",   32'(ex_wreg_o),   32'd1);
    check("ori_valid",  32'(ex_valid_o),  32'd1);
    check("ori_pc",     ex_pc_o,          32'h0000_0100);

    // Both sources write $3; the younger (src0) must win.
    pc_i = 32'h0000_0104;
    inst_i = r_type(5'd3, 5'd3, 5'd4, 5'd0, 6'h21);
    fwd_we_i = 2'b11; fwd_waddr_i = {5'd3, 5'd3}; fwd_wdata_i = {32'hBB, 32'hAA};
    #1 check("fwd_nostall", 32'(stallreq_o), 32'd0);
    tick();
    check("fwd_reg1",   ex_reg1_o,        32'hAA);
    check("fwd_reg2",   ex_reg2_o,        32'hAA);
    check("addu_aluop", 32'(ex_aluop_o),  32'h21);
    check("addu_sel",   32'(ex_alusel_o), 32'd4);
    check("addu_waddr", 32'(ex_waddr_o),  32'd4);

    fwd_waddr_i = {5'd3, 5'd9};
    tick();
    check("fwd_src1", ex_reg1_o, 32'hBB);

    fwd_we_i = 2'b01; fwd_waddr_i = {5'd0, 5'd0}; fwd_wdata_i = {32'h0, 32'h55};
    inst_i = r_type(5'd0, 5'd0, 5'd4, 5'd0, 6'h21);
    tick();
    check("zero_reg1", ex_reg1_o, 32'd0);
    check("zero_reg2", ex_reg2_o, 32'd0);

    // Load-use: src0 has a pending load to $2.
    fwd_we_i = 2'b01; fwd_waddr_i = {5'd0, 5'd2}; fwd_wdata_i = '0; fwd_pending_i = 2'b01;
    inst_i = r_type(5'd2, 5'd6, 5'd5, 5'd0, 6'h23);
    #1 check("lu_stallreq", 32'(stallreq_o), 32'd1);
    tick();
    check("lu_bubble_valid", 32'(ex_valid_o), 32'd0);
    check("lu_bubble_wreg",  32'(ex_wreg_o),  32'd0);
    fwd_we_i = 2'b10; fwd_waddr_i = {5'd2, 5'd0}; fwd_wdata_i = {32'd7, 32'd0}; fwd_pending_i = 2'b00;
    #1 check("lu_cleared", 32'(stallreq_o), 32'd0);
    tick();
    check("lu_reg1",  ex_reg1_o,       32'd7);
    check("lu_reg2",  ex_reg2_o,       32'h106);
    check("lu_aluop", 32'(ex_aluop_o), 32'h23);
    check("lu_waddr", 32'(ex_waddr_o), 32'd5);
    check("lu_valid", 32'(ex_valid_o), 32'd1);

    // Only the highest-priority match matters: src0 ready, src1 pending.
    fwd_we_i = 2'b11; fwd_waddr_i = {5'd2, 5'd2}; fwd_wdata_i = {32'd1, 32'd9}; fwd_pending_i = 2'b10;
    #1 check("prio_pend", 32'(stallreq_o), 32'd0);
    fwd_clear();

    inst_i = i_type(6'h09, 5'd0, 5'd7, 16'hFFFF);
    tick();
    check("addiu_reg2", ex_reg2_o, 32'hFFFF_FFFF);
    inst_i = i_type(6'h0C, 5'd0, 5'd7, 16'hFFFF);
    tick();
    check("andi_reg2",  ex_reg2_o,       32'h0000_FFFF);
    check("andi_aluop", 32'(ex_aluop_o), 32'h24);
    inst_i = r_type(5'd0, 5'd2, 5'd1, 5'd4, 6'h00);
    tick();
    check("sll_reg2",  ex_reg2_o,        32'd4);
    check("sll_reg1",  ex_reg1_o,        32'h102);
    check("sll_aluop", 32'(ex_aluop_o),  32'h7C);
    check("sll_sel",   32'(ex_alusel_o), 32'd2);
    inst_i = r_type(5'd5, 5'd4, 5'd3, 5'd0, 6'h06);
    tick();
    check("srlv_reg1", ex_reg1_o, 32'h104);
    check("srlv_reg2", ex_reg2_o, 32'h105);
    inst_i = i_type(6'h0F, 5'd0, 5'd8, 16'hABCD);
    tick();
    check("lui_reg2",  ex_reg2_o,       32'hABCD_0000);
    check("lui_reg1",  ex_reg1_o,       32'd0);
    check("lui_waddr", 32'(ex_waddr_o), 32'd8);

    inst_i = {6'h3F, 26'h0};
    tick();
    check("rsvd_flag",  32'(ex_rsvd_o),  32'd1);
    check("rsvd_wreg",  32'(ex_wreg_o),  32'd0);
    check("rsvd_aluop", 32'(ex_aluop_o), 32'd0);

    inst_i = r_type(5'd0, 5'd0, 5'd0, 5'd0, 6'h0F);
    tick();
    check("sync_wreg", 32'(ex_wreg_o), 32'd0);
    check("sync_rsvd", 32'(ex_rsvd_o), 32'd0);

    inst_i = i_type(6'h0D, 5'd0, 5'd1, 16'h1234);
    tick();
    stall_i = 1'b1;
    inst_i = r_type(5'd3, 5'd3, 5'd4, 5'd0, 6'h21);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_waddr", 32'(ex_waddr_o), 32'd1);
      check("hold_reg2",  ex_reg2_o,       32'h1234);
    end
    flush_i = 1'b1;
    tick();
    check("flush_valid", 32'(ex_valid_o), 32'd0);
    check("flush_reg2",  ex_reg2_o,       32'd0);
    flush_i = 1'b0; stall_i = 1'b0;

    inst_i = i_type(6'h0D, 5'd0, 5'd9, 16'h0009);
    tick();
    stall_i = 1'b1;
    fwd_we_i = 2'b01; fwd_waddr_i = {5'd0, 5'd2}; fwd_pending_i = 2'b01;
    inst_i = r_type(5'd2, 5'd6, 5'd5, 5'd0, 6'h23);
    tick();
    check("stall_wins_valid", 32'(ex_valid_o), 32'd1);
    check("stall_wins_waddr", 32'(ex_waddr_o), 32'd9);
    rst = 1'b1;
    tick();
    check("rst_mid_valid", 32'(ex_valid_o), 32'd0);
    check("rst_mid_waddr", 32'(ex_waddr_o), 32'd0);
    rst = 1'b0; stall_i = 1'b0;

    inst_valid_i = 1'b0;
    #1 check("invalid_nostall", 32'(stallreq_o), 32'd0);
    fwd_clear();
    inst_i = i_type(6'h0D, 5'd0, 5'd1, 16'h1234);
    tick();
    check("invalid_valid", 32'(ex_valid_o), 32'd0);
    check("invalid_wreg",  32'(ex_wreg_o),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
